// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA raster timing generator with a 2-stage request/colour pipeline to the DAC pins.
// Issues per-pixel requests upstream and aligns returned colour with the sync outputs.
module vga_scan_out #(
    parameter int VGA_WIDHT = 6,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [VGA_WIDHT-1:0] red_i,
    input  logic [VGA_WIDHT-1:0] green_i,
    input  logic [VGA_WIDHT-1:0] blue_i,
    output logic                 pix_req_o,
    output logic [9:0]           pix_x_o,
    output logic [9:0]           pix_y_o,
    output logic                 frame_start_o,
    output logic [VGA_WIDHT-1:0] red_o,
    output logic [VGA_WIDHT-1:0] green_o,
    output logic [VGA_WIDHT-1:0] blue_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 active_o
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

    logic [9:0]           h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                 h_wrap, hs, vs;
    logic                 req_d1_q, hs_d1_q, vs_d1_q;
    logic [VGA_WIDHT-1:0] red_q, green_q, blue_q;
    logic                 hsync_q, vsync_q, active_q;

    always_comb begin
        h_wrap        = h_cnt_q == H_LAST;
        h_cnt_d       = (!en_i || h_wrap) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d       = !en_i ? 10'd0 : !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        // Gated by reset so the combinational request side also shows idle values while reset is held.
        pix_req_o     = en_i && !rst_i && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        frame_start_o = en_i && !rst_i && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        pix_x_o       = pix_req_o ? h_cnt_q : 10'd0;
        pix_y_o       = pix_req_o ? v_cnt_q : 10'd0;
        hs            = (h_cnt_q >= H_SS) && (h_cnt_q <= H_SE);
        vs            = (v_cnt_q >= V_SS) && (v_cnt_q <= V_SE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            req_d1_q <= 1'b0;
            hs_d1_q  <= 1'b0;
            vs_d1_q  <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            active_q <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            req_d1_q <= pix_req_o;
            hs_d1_q  <= hs;
            vs_d1_q  <= vs;
            red_q    <= req_d1_q ? red_i : '0;
            green_q  <= req_d1_q ? green_i : '0;
            blue_q   <= req_d1_q ? blue_i : '0;
            active_q <= req_d1_q;
            hsync_q  <= hs_d1_q ^ ~SYNC_POL;
            vsync_q  <= vs_d1_q ^ ~SYNC_POL;
        end
    end

    assign red_o    = red_q;
    assign green_o  = green_q;
    assign blue_o   = blue_q;
    assign active_o = active_q;
    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;
endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: checks request timing, sync placement, colour pipeline, EN drop and async reset.
// A small-timing instance with active-high sync covers whole-frame behaviour.
module tb_vga_scan_out;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic [5:0] red_i = 6'h3F, green_i = 6'h3F, blue_i = 6'h3F;
    logic pix_req_o, frame_start_o, hsync_o, vsync_o, active_o;
    logic [9:0] pix_x_o, pix_y_o;
    logic [5:0] red_o, green_o, blue_o;

    logic rst_s = 1'b1;
    logic en_s = 1'b1;
    logic [5:0] s_col = 6'h3F;
    logic s_req, s_fs, s_hs, s_vs, s_act;
    logic [9:0] s_x, s_y;
    logic [5:0] s_r, s_g, s_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_scan_out u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .pix_req_o(pix_req_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .frame_start_o(frame_start_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o)
    );

    vga_scan_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_small (
        .clk_i(clk), .rst_i(rst_s), .en_i(en_s),
        .red_i(s_col), .green_i(s_col), .blue_i(s_col),
        .pix_req_o(s_req), .pix_x_o(s_x), .pix_y_o(s_y), .frame_start_o(s_fs),
        .red_o(s_r), .green_o(s_g), .blue_o(s_b),
        .hsync_o(s_hs), .vsync_o(s_vs), .active_o(s_act)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: each request's expected colour is queued and popped when it reaches the pins.
    typedef struct packed { logic act; logic [5:0] r, g, b; } pix_t;
    pix_t sb[$];
    pix_t e;
    logic prev_req = 1'b0;
    logic [9:0] prev_x = '0, prev_y = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_values",
                {pix_req_o, pix_x_o, pix_y_o, frame_start_o, red_o, green_o, blue_o, active_o, hsync_o, vsync_o},
                {1'b0, 10'd0, 10'd0, 1'b0, 18'd0, 1'b0, 1'b1, 1'b1});
            sb.delete();
            sb.push_back('0);
            sb.push_back('0);
            prev_req = 1'b0;
        end else begin
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                chk("pix_out", {active_o, red_o, green_o, blue_o}, e);
            end
            sb.push_back(pix_req_o ? pix_t'{1'b1, pix_x_o[5:0], pix_y_o[5:0], pix_x_o[5:0] ^ pix_y_o[5:0]} : pix_t'('0));
        end
        // Source model: colour for the previous clock's request, all-ones during blanking.
        red_i   = prev_req ? prev_x[5:0] : 6'h3F;
        green_i = prev_req ? prev_y[5:0] : 6'h3F;
        blue_i  = prev_req ? prev_x[5:0] ^ prev_y[5:0] : 6'h3F;
        prev_req = pix_req_o;
        prev_x = pix_x_o;
        prev_y = pix_y_o;
    end

    typedef struct { int cyc; logic req; logic [9:0] x, y; logic fs, hs; } vec_t;
    vec_t vt[12];

    initial begin
        int k, req_cnt, hs_cnt, hs_first, fs_cnt, fs_first, fs_second, vs_cnt, vs_first, sh_cnt, act_cnt;
        bit found;
        vt[0]  = '{0,    1'b1, 10'd0,   10'd0, 1'b1, 1'b1};
        vt[1]  = '{1,    1'b1, 10'd1,   10'd0, 1'b0, 1'b1};
        vt[2]  = '{639,  1'b1, 10'd639, 10'd0, 1'b0, 1'b1};
        vt[3]  = '{640,  1'b0, 10'd0,   10'd0, 1'b0, 1'b1};
        vt[4]  = '{657,  1'b0, 10'd0,   10'd0, 1'b0, 1'b1};
        vt[5]  = '{658,  1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
        vt[6]  = '{753,  1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
        vt[7]  = '{754,  1'b0, 10'd0,   10'd0, 1'b0, 1'b1};
        vt[8]  = '{799,  1'b0, 10'd0,   10'd0, 1'b0, 1'b1};
        vt[9]  = '{800,  1'b1, 10'd0,   10'd1, 1'b0, 1'b1};
        vt[10] = '{801,  1'b1, 10'd1,   10'd1, 1'b0, 1'b1};
        vt[11] = '{1605, 1'b1, 10'd5,   10'd2, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        k = 0; req_cnt = 0; hs_cnt = 0; hs_first = -1;
        for (int c = 0; c <= 1605; c++) begin
            @(negedge clk);
            if (c < 800) begin
                req_cnt += int'(pix_req_o);
                if (!hsync_o) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = c;
                end
            end
            if (k < 12 && vt[k].cyc == c) begin
                chk($sformatf("vec%0d", k), {pix_req_o, pix_x_o, pix_y_o, frame_start_o, hsync_o},
                    {vt[k].req, vt[k].x, vt[k].y, vt[k].fs, vt[k].hs});
                k++;
            end
        end
        chk("line_req_cnt", req_cnt, 640);
        chk("line_hs_low_cnt", hs_cnt, 96);
        chk("line_hs_first", hs_first, 658);

        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            found = pix_req_o && pix_x_o == 10'd99 && pix_y_o == 10'd5;
        end
        chk("wait_x99_y5", found, 1'b1);
        @(posedge clk);
        #1 en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_off_no_req", {pix_req_o, frame_start_o}, 2'b00);
            if (i == 0) chk("drain_px98", {active_o, red_o}, {1'b1, 6'd34});
            if (i == 1) chk("drain_px99", {active_o, red_o}, {1'b1, 6'd35});
            if (i == 2) chk("drain_done", {active_o, red_o}, {1'b0, 6'd0});
        end
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        chk("en_restart", {pix_req_o, pix_x_o, pix_y_o, frame_start_o}, {1'b1, 10'd0, 10'd0, 1'b1});

        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            found = pix_req_o && pix_x_o == 10'd299;
        end
        chk("wait_x299", found, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset",
            {pix_req_o, pix_x_o, frame_start_o, red_o, green_o, blue_o, active_o, hsync_o, vsync_o},
            {1'b0, 10'd0, 1'b0, 18'd0, 1'b0, 1'b1, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_restart", {pix_req_o, pix_x_o, pix_y_o, frame_start_o}, {1'b1, 10'd0, 10'd0, 1'b1});
        repeat (4) @(negedge clk);

        chk("small_reset_sync", {s_hs, s_vs, s_act}, 3'b000);
        @(posedge clk);
        #1 rst_s = 1'b0;
        fs_cnt = 0; fs_first = -1; fs_second = -1; vs_cnt = 0; vs_first = -1; sh_cnt = 0; act_cnt = 0;
        for (int c = 0; c < 360; c++) begin
            @(negedge clk);
            if (s_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
            if (c < 120) begin
                sh_cnt += int'(s_hs);
                act_cnt += int'(s_act);
                if (s_vs) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = c;
                end
            end
        end
        chk("frame_fs_cnt", fs_cnt, 3);
        chk("frame_fs_first", fs_first, 0);
        chk("frame_fs_period", fs_second - fs_first, 120);
        chk("frame_vs_cnt", vs_cnt, 30);
        chk("frame_vs_first", vs_first, 77);
        chk("frame_hs_cnt", sh_cnt, 24);
        chk("frame_active_cnt", act_cnt, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
